serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 20 ++
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } sa_state_t;

    // Bit counter must be at least one bit wide even for the narrowest adders.
    function automatic int unsigned sa_cnt_width(input int unsigned width);
        return (width <= 32'd2) ? 32'd1 : 32'($clog2(width));
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder built from two half adders and an OR.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    assign ha0_sum   = a ^ b;
    assign ha0_carry = a & b;
    assign sum       = ha0_sum ^ cin;
    assign ha1_carry = ha0_sum & cin;
    assign carry     = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder {carry, sum} = a + b + cin with valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned    CW   = sa_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             fa_sum;
    logic             fa_carry;
    logic             unused_acc_lsb;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_adder u_full_adder (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // The accumulator LSB is shifted out every ADD cycle and never read.
    assign unused_acc_lsb = acc_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                acc_d  = {fa_sum, acc_q[WIDTH-1:1]};
                c_d    = fa_carry;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = acc_d;
                    carry_d = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // c_q is the carry into the MSB during the final bit.
                    ovf_d   = c_q ^ fa_carry;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD) || (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder at WIDTH=8 and an exhaustive run at WIDTH=2.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, carry8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, carry2, busy2;
    logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf2;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .carry     (carry8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf8),
`endif
        .busy      (busy8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .cin       (cin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .carry     (carry2),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf2),
`endif
        .busy      (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One WIDTH=8 transaction; hold = number of DONE cycles with out_ready low.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input int unsigned hold);
        logic [8:0]  ref_full;
        int          s_sig;
        logic        ref_ovf;
        int unsigned n;
        ref_full = 9'(ta) + 9'(tb_) + 9'(tc);
        s_sig    = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
        ref_ovf  = (s_sig > 127) || (s_sig < -128);

        check("idle_in_ready", 32'(in_ready8), 32'd1);
        a8 = ta; b8 = tb_; cin8 = tc; in_valid8 = 1'b1;
        out_ready8 = (hold == 0);
        tick();
        check("add_in_ready", 32'(in_ready8), 32'd0);
        check("add_busy", 32'(busy8), 32'd1);
        n = 0;
        while (!out_valid8 && n < 40) begin
            in_valid8 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            tick();
            n++;
        end
        check("latency", n, 32'd8);
        check("sum", 32'(sum8), 32'(ref_full[7:0]));
        check("carry", 32'(carry8), 32'(ref_full[8]));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf8), 32'(ref_ovf));
`endif
        check("done_in_ready", 32'(in_ready8), 32'd0);
        check("done_busy", 32'(busy8), 32'd1);
        for (int unsigned h = 0; h < hold; h++) begin
            in_valid8 = 1'b1;
            tick();
            check("hold_valid", 32'(out_valid8), 32'd1);
            check("hold_sum", 32'(sum8), 32'(ref_full[7:0]));
            check("hold_carry", 32'(carry8), 32'(ref_full[8]));
            check("hold_in_ready", 32'(in_ready8), 32'd0);
        end
        out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        check("consumed_valid", 32'(out_valid8), 32'd0);
        check("consumed_in_ready", 32'(in_ready8), 32'd1);
        check("consumed_busy", 32'(busy8), 32'd0);
        check("idle_sum_kept", 32'(sum8), 32'(ref_full[7:0]));
    endtask

    initial begin
        int unsigned n;
        int unsigned prev_acc;
        logic [4:0]  v;
        logic [2:0]  ref3;
        logic        seen_valid;

        rst = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready8), 32'd0);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_carry", 32'(carry8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf8), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready8), 32'd1);

        run8(8'h00, 8'h00, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 0);
        run8(8'hA5, 8'h5A, 1'b1, 5);
        run8(8'h7F, 8'h01, 1'b0, 1);

        // Reset during the third ADD cycle discards the transaction.
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        tick();
        check("mid_add_busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready8), 32'd0);
        tick();
        check("mid_rst_sum", 32'(sum8), 32'd0);
        check("mid_rst_carry", 32'(carry8), 32'd0);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready_after", 32'(in_ready8), 32'd1);
        seen_valid = 1'b0;
        for (int unsigned k = 0; k < 12; k++) begin
            tick();
            if (out_valid8) seen_valid = 1'b1;
        end
        check("mid_rst_no_valid", 32'(seen_valid), 32'd0);
        check("mid_rst_sum_idle", 32'(sum8), 32'd0);
        run8(8'h10, 8'h20, 1'b0, 0);

        for (int unsigned r = 0; r < 20; r++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        // Exhaustive WIDTH=2 with in_valid and out_ready held high.
        in_valid2 = 1'b1;
        out_ready2 = 1'b1;
        prev_acc = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            v = 5'(i);
            a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0];
            ref3 = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
            n = 0;
            while (!in_ready2 && n < 20) begin
                tick();
                n++;
            end
            check("w2_in_ready", 32'(in_ready2), 32'd1);
            tick();
            if (i > 0) check("w2_interval", cyc - prev_acc, 32'd4);
            prev_acc = cyc;
            n = 0;
            while (!out_valid2 && n < 20) begin
                tick();
                n++;
            end
            check("w2_latency", n, 32'd2);
            check("w2_sum", 32'(sum2), 32'(ref3[1:0]));
            check("w2_carry", 32'(carry2), 32'(ref3[2]));
            tick();
        end
        in_valid2 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
